// File: rtl/bluejay_data_if.sv
// ----------------------------------------------------------------------------
// bluejay_data_if
//   Bundle of the line-FIFO read port and the Bluejay display output port.
//
//   start_clocking_frame_data : level request to clock out one frame
//   fifo_data_out             : FIFO read data, valid one cycle after a strobe
//   line_of_data_available    : FIFO holds at least one complete line
//   fifo_empty                : FIFO empty flag
//   get_next_word             : FIFO read strobe, one word per high cycle
//   data_o                    : pixel word to the display
//   sync                      : one-cycle line-start pulse
//   valid                     : data_o carries a new word this cycle
//
//   master : the bluejay_data block (consumes FIFO, drives display)
//   slave  : the environment (FIFO + display side)
// ----------------------------------------------------------------------------
interface bluejay_data_if;
    logic        start_clocking_frame_data;
    logic [31:0] fifo_data_out;
    logic        line_of_data_available;
    logic        fifo_empty;
    logic        get_next_word;
    logic [31:0] data_o;
    logic        sync;
    logic        valid;

    modport master (
        input  start_clocking_frame_data,
        input  fifo_data_out,
        input  line_of_data_available,
        input  fifo_empty,
        output get_next_word,
        output data_o,
        output sync,
        output valid
    );

    modport slave (
        output start_clocking_frame_data,
        output fifo_data_out,
        output line_of_data_available,
        output fifo_empty,
        input  get_next_word,
        input  data_o,
        input  sync,
        input  valid
    );
endinterface

// File: rtl/bluejay_data.sv
// ----------------------------------------------------------------------------
// bluejay_data
//   Reads display lines out of a line FIFO and clocks them to the Bluejay
//   display. Each line is announced by a one-cycle sync pulse, followed by
//   WORDS_PER_LINE FIFO reads and GAP_CYCLES idle cycles. A frame is
//   LINES_PER_FRAME lines; a new frame starts only when the start level is
//   seen in IDLE.
//
//   Ports:
//     fpga_clk : clock, all state on its rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : bluejay_data_if.master (FIFO read port + display output)
//
//   Parameters:
//     WORDS_PER_LINE  : 32-bit words per display line
//     LINES_PER_FRAME : lines per frame
//     GAP_CYCLES      : idle cycles after each line's last FIFO read
// ----------------------------------------------------------------------------
module bluejay_data #(
    parameter int unsigned WORDS_PER_LINE  = 40,
    parameter int unsigned LINES_PER_FRAME = 1024,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input  logic            fpga_clk,
    input  logic            reset_n,
    bluejay_data_if.master  bus
);

    localparam int unsigned WW = $clog2(WORDS_PER_LINE) + 1;
    localparam int unsigned LW = $clog2(LINES_PER_FRAME) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

    localparam logic [WW-1:0] WORD_MAX = WW'(WORDS_PER_LINE);
    localparam logic [LW-1:0] LINE_MAX = LW'(LINES_PER_FRAME);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        SYNC,
        READ,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] word_cnt_q, word_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    logic          rd;
    logic          rd_d1;
    logic [31:0]   data_q;
    logic          valid_q;

    // ------------------------------------------------------------------------
    // Next-state, counter updates and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        // The SYNC cycle already reads word 0; an empty FIFO stalls the read
        // without leaving the line.
        rd = ((state_q == SYNC) || (state_q == READ)) &&
             !bus.fifo_empty && (word_cnt_q < WORD_MAX);

        unique case (state_q)
            IDLE: begin
                if (bus.start_clocking_frame_data) begin
                    state_d    = WAIT_LINE;
                    line_cnt_d = '0;
                end
            end

            WAIT_LINE: begin
                if (bus.line_of_data_available && !bus.fifo_empty) begin
                    state_d    = SYNC;
                    word_cnt_d = '0;
                end
            end

            SYNC, READ: begin
                state_d = READ;
                if (rd) begin
                    word_cnt_d = word_cnt_q + WW'(1);
                    if (word_cnt_q + WW'(1) == WORD_MAX) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end
            end

            GAP: begin
                // A GAP_CYCLES of zero still spends one cycle here.
                if (gap_cnt_q + GW'(1) >= GAP_MAX) begin
                    gap_cnt_d  = '0;
                    line_cnt_d = line_cnt_q + LW'(1);
                    if (line_cnt_q + LW'(1) == LINE_MAX)
                        state_d = IDLE;
                    else
                        state_d = WAIT_LINE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output pipeline: strobe in cycle N, FIFO data present in N+1 and
    // captured at its end, so data_o/valid appear in N+2. data_o holds its
    // last word whenever nothing new arrives.
    // ------------------------------------------------------------------------
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_d1   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            rd_d1   <= rd;
            valid_q <= rd_d1;
            if (rd_d1)
                data_q <= bus.fifo_data_out;
        end
    end

    assign bus.get_next_word = rd;
    assign bus.sync          = (state_q == SYNC);
    assign bus.data_o        = data_q;
    assign bus.valid         = valid_q;

endmodule

// File: tb/tb_bluejay_data.sv
module tb_bluejay_data;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int unsigned rd_ptr = 0;
    int tests = 0;
    int fails = 0;

    bluejay_data_if bus ();

    bluejay_data #(
        .WORDS_PER_LINE  (4),
        .LINES_PER_FRAME (2),
        .GAP_CYCLES      (2)
    ) dut (
        .fpga_clk (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Line FIFO model: word k holds 0x10 + k, presented the cycle after a strobe.
    always @(posedge clk) begin
        if (bus.get_next_word) begin
            bus.fifo_data_out <= 32'h10 + rd_ptr;
            rd_ptr <= rd_ptr + 1;
        end
    end

    typedef struct {
        logic        start;
        logic        avail;
        logic        empty;
        logic        e_sync;
        logic        e_gnw;
        logic        e_valid;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(logic s, logic a, logic e,
                              logic es, logic eg, logic ev, logic [31:0] ed);
        vec_t t;
        t.start = s; t.avail = a; t.empty = e;
        t.e_sync = es; t.e_gnw = eg; t.e_valid = ev; t.e_data = ed;
        vecs.push_back(t);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic s, logic a, logic e);
        bus.start_clocking_frame_data = s;
        bus.line_of_data_available    = a;
        bus.fifo_empty                = e;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic found;

        // Frame 1: two clean lines, start dropped after the first sync,
        // line_avail toggled outside WAIT_LINE.
        v(1,1,0, 0,0,0,32'h00);  // c0  IDLE
        v(1,1,0, 0,0,0,32'h00);  // c1  WAIT_LINE
        v(1,1,0, 1,1,0,32'h00);  // c2  SYNC, word 0
        v(0,1,0, 0,1,0,32'h00);  // c3
        v(0,0,0, 0,1,1,32'h10);  // c4
        v(0,1,0, 0,1,1,32'h11);  // c5  last read
        v(0,0,0, 0,0,1,32'h12);  // c6  GAP
        v(0,1,0, 0,0,1,32'h13);  // c7  GAP
        v(0,1,0, 0,0,0,32'h13);  // c8  WAIT_LINE
        v(0,1,0, 1,1,0,32'h13);  // c9  SYNC line 2
        v(0,1,0, 0,1,0,32'h13);
        v(0,1,0, 0,1,1,32'h14);
        v(0,1,0, 0,1,1,32'h15);
        v(0,1,0, 0,0,1,32'h16);
        v(0,1,0, 0,0,1,32'h17);
        v(0,1,0, 0,0,0,32'h17);  // c15 IDLE, start low
        v(0,1,0, 0,0,0,32'h17);
        v(0,1,0, 0,0,0,32'h17);
        // Frame 2, line 1: three-cycle empty stall after the second read.
        v(1,1,0, 0,0,0,32'h17);  // c18 IDLE
        v(1,1,0, 0,0,0,32'h17);  // c19 WAIT_LINE
        v(1,1,0, 1,1,0,32'h17);  // c20 SYNC
        v(1,1,0, 0,1,0,32'h17);
        v(1,1,1, 0,0,1,32'h18);  // stall
        v(1,1,1, 0,0,1,32'h19);  // stall
        v(1,1,1, 0,0,0,32'h19);  // stall
        v(1,1,0, 0,1,0,32'h19);
        v(1,1,0, 0,1,0,32'h19);
        v(1,1,0, 0,0,1,32'h1A);
        v(1,1,0, 0,0,1,32'h1B);
        // Frame 2, line 2: line_avail low for 10 cycles in WAIT_LINE.
        for (int i = 0; i < 10; i++)
            v(0,0,0, 0,0,0,32'h1B);
        v(0,1,0, 0,0,0,32'h1B);  // c39 avail rises
        v(0,1,0, 1,1,0,32'h1B);  // c40 SYNC
        v(0,1,0, 0,1,0,32'h1B);
        v(0,1,0, 0,1,1,32'h1C);
        v(0,1,0, 0,1,1,32'h1D);
        v(0,1,0, 0,0,1,32'h1E);
        v(0,1,0, 0,0,1,32'h1F);
        v(0,1,0, 0,0,0,32'h1F);  // IDLE
        v(0,1,0, 0,0,0,32'h1F);

        // Reset state
        drive(1'b1, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset sync",  {31'b0, bus.sync},          32'h0);
        chk("reset gnw",   {31'b0, bus.get_next_word}, 32'h0);
        chk("reset valid", {31'b0, bus.valid},         32'h0);
        chk("reset data",  bus.data_o,                 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].avail, vecs[i].empty);
            @(negedge clk);
            chk($sformatf("v%0d sync", i),  {31'b0, bus.sync},          {31'b0, vecs[i].e_sync});
            chk($sformatf("v%0d gnw", i),   {31'b0, bus.get_next_word}, {31'b0, vecs[i].e_gnw});
            chk($sformatf("v%0d valid", i), {31'b0, bus.valid},         {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d data", i),  bus.data_o,                 vecs[i].e_data);
            next_cycle();
        end

        // Reset asserted mid-READ
        drive(1'b1, 1'b1, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.sync) found = 1'b1;
            else next_cycle();
        end
        chk("rst_seq sync seen", {31'b0, found}, 32'h1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_seq valid before", {31'b0, bus.valid}, 32'h1);
        chk("rst_seq data before",  bus.data_o,         32'h20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_seq sync",  {31'b0, bus.sync},          32'h0);
        chk("rst_seq gnw",   {31'b0, bus.get_next_word}, 32'h0);
        chk("rst_seq valid", {31'b0, bus.valid},         32'h0);
        chk("rst_seq data",  bus.data_o,                 32'h0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst idle sync %0d", k), {31'b0, bus.sync},          32'h0);
            chk($sformatf("post_rst idle gnw %0d", k),  {31'b0, bus.get_next_word}, 32'h0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst noavail sync %0d", k), {31'b0, bus.sync},          32'h0);
            chk($sformatf("post_rst noavail gnw %0d", k),  {31'b0, bus.get_next_word}, 32'h0);
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst avail sync", {31'b0, bus.sync}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("post_rst restart sync", {31'b0, bus.sync},          32'h1);
        chk("post_rst restart gnw",  {31'b0, bus.get_next_word}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
